// File: rtl/fu_share_arb_pkg.sv
// fu_share_arb_pkg: shared types and constants for the shared functional-unit arbiter.
// Holds the FSM state type, LFSR tap mask, index width and default seed.
package fu_share_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // x^8 + x^6 + x^5 + x^4 + 1, i.e. fb = q7 ^ q5 ^ q4 ^ q3
  localparam logic [7:0] LFSR_TAPS     = 8'hB8;
  localparam logic [7:0] LFSR_SEED_DEF = 8'hA5;
  localparam int         N_REQ_DEF     = 4;
  localparam int         IDX_W         = $clog2(N_REQ_DEF);

  function automatic logic [31:0] lfsr_taps(input int w);
    case (w)
      4:       return 32'h0000_000C;
      5:       return 32'h0000_0014;
      6:       return 32'h0000_0030;
      7:       return 32'h0000_0060;
      8:       return {24'h0, LFSR_TAPS};
      16:      return 32'h0000_B400;
      default: return 32'(3) << (w - 2);
    endcase
  endfunction

endpackage

// File: rtl/lfsr_prio_gen.sv
// lfsr_prio_gen: free-running Fibonacci LFSR that supplies the rotating start index.
// Reloads the seed on flush; the top tap is always set so the register never reaches zero.
module lfsr_prio_gen
  import fu_share_arb_pkg::*;
#(
  parameter int                LFSR_W    = 8,
  parameter logic [LFSR_W-1:0] LFSR_SEED = LFSR_W'(LFSR_SEED_DEF),
  parameter int                IW        = IDX_W
)(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  output logic [IW-1:0] start_idx
);

  localparam logic [LFSR_W-1:0] TAPS = LFSR_W'(lfsr_taps(LFSR_W));

  logic [LFSR_W-1:0] q;
  logic              fb;

  assign fb = ^(q & TAPS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= LFSR_SEED;
    end else if (flush) begin
      q <= LFSR_SEED;
    end else begin
      q <= {q[LFSR_W-2:0], fb};
    end
  end

  assign start_idx = q[IW-1:0];

endmodule

// File: rtl/fu_share_arb.sv
// fu_share_arb: grants one of N_REQ requesters to a shared non-pipelined multi-cycle unit.
// Optional starvation guard enabled by defining FU_SHARE_ARB_STARVE_GUARD_EN.
//
// state | meaning
// IDLE  | unit free, grant allowed
// BUSY  | op in flight, cnt counts down; grant allowed again at cnt==0
module fu_share_arb
  import fu_share_arb_pkg::*;
#(
  parameter int                N_REQ     = 4,
  parameter int                TAG_W     = 6,
  parameter int                OP_LAT    = 4,
  parameter int                LFSR_W    = 8,
  parameter logic [LFSR_W-1:0] LFSR_SEED = LFSR_W'(LFSR_SEED_DEF)
`ifdef FU_SHARE_ARB_STARVE_GUARD_EN
  , parameter int              STARVE_LIM = 8
`endif
)(
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*TAG_W-1:0]     req_tag,
  output logic [N_REQ-1:0]           req_ready,
  output logic                       fu_valid,
  output logic [TAG_W-1:0]           fu_tag,
  output logic [$clog2(N_REQ)-1:0]   fu_src,
  output logic                       done_valid,
  output logic [TAG_W-1:0]           done_tag,
  output logic                       busy
);

  localparam int            IW       = $clog2(N_REQ);
  localparam int            CW       = $clog2(OP_LAT);
  localparam logic [CW-1:0] CNT_LOAD = CW'(OP_LAT - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] start_idx, scan_idx, pick_idx;
  logic          pick_valid, grant_win, grant, done_d;

  lfsr_prio_gen #(
    .LFSR_W    (LFSR_W),
    .LFSR_SEED (LFSR_SEED),
    .IW        (IW)
  ) u_lfsr (
    .clk       (clk),
    .rst_n     (reset),
    .flush     (flush),
    .start_idx (start_idx)
  );

  // Scan from the far end so the first valid at or after start_idx is the last write.
  always_comb begin
    scan_idx   = '0;
    pick_valid = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req_valid[start_idx + IW'(k)]) begin
        pick_valid = 1'b1;
        scan_idx   = start_idx + IW'(k);
      end
    end
  end

`ifdef FU_SHARE_ARB_STARVE_GUARD_EN
  localparam int AW = $clog2(STARVE_LIM + 1);

  logic [N_REQ-1:0][AW-1:0] age_q;
  logic                     starve_any;
  logic [IW-1:0]            starve_idx;

  always_comb begin
    starve_any = 1'b0;
    starve_idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_valid[i] && (age_q[i] >= AW'(STARVE_LIM))) begin
        starve_any = 1'b1;
        starve_idx = IW'(i);
      end
    end
  end

  assign pick_idx = starve_any ? starve_idx : scan_idx;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      age_q <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (flush || !req_valid[i] || req_ready[i]) begin
          age_q[i] <= '0;
        end else if (age_q[i] != AW'(STARVE_LIM)) begin
          age_q[i] <= age_q[i] + 1'b1;
        end
      end
    end
  end
`else
  assign pick_idx = scan_idx;
`endif

  // IDLE always holds cnt at zero, so cnt==0 also covers the back-to-back slot.
  assign grant_win = reset && !flush && ((state_q == IDLE) || (cnt_q == '0));
  assign req_ready = (grant_win && pick_valid) ? (N_REQ'(1) << pick_idx) : '0;
  assign grant     = |req_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (grant) begin
      state_d = BUSY;
      cnt_d   = CNT_LOAD;
      done_d  = (state_q == BUSY);
    end else if (state_q == BUSY) begin
      if (cnt_q == '0) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      fu_valid   <= 1'b0;
      fu_tag     <= '0;
      fu_src     <= '0;
      done_valid <= 1'b0;
      done_tag   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      fu_valid   <= grant;
      done_valid <= done_d;
      if (grant) begin
        fu_tag <= req_tag[int'(pick_idx)*TAG_W +: TAG_W];
        fu_src <= pick_idx;
      end
      // fu_tag still holds the in-flight tag here, even when a new launch overwrites it
      if (done_d) begin
        done_tag <= fu_tag;
      end
    end
  end

  assign busy = (state_q == BUSY);

endmodule

// File: tb/tb_fu_share_arb.sv
// tb_fu_share_arb: directed table, corner-case sequences and random traffic against a
// cycle-stamped reference model of the shared-FU arbiter.
module tb_fu_share_arb;

  localparam int N   = 4;
  localparam int TW  = 6;
  localparam int LAT = 4;
`ifdef FU_SHARE_ARB_STARVE_GUARD_EN
  localparam int STARVE_LIM = 8;
`endif

  logic          clk = 1'b0;
  logic          reset, flush;
  logic [N-1:0]  req_valid;
  logic [N*TW-1:0] req_tag;
  logic [N-1:0]  req_ready;
  logic          fu_valid;
  logic [TW-1:0] fu_tag;
  logic [1:0]    fu_src;
  logic          done_valid;
  logic [TW-1:0] done_tag;
  logic          busy;

  fu_share_arb dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .req_valid  (req_valid),
    .req_tag    (req_tag),
    .req_ready  (req_ready),
    .fu_valid   (fu_valid),
    .fu_tag     (fu_tag),
    .fu_src     (fu_src),
    .done_valid (done_valid),
    .done_tag   (done_tag),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // Reference model: absolute cycle stamps instead of a countdown.
  logic [7:0]    m_lfsr;
  bit            m_act;
  int            m_end;
  logic [TW-1:0] m_tag;
  bit            m_fu_v;
  logic [TW-1:0] m_fu_tag;
  logic [1:0]    m_fu_src;
  bit            m_dn_v;
  logic [TW-1:0] m_dn_tag;
  int            m_age [N];
  logic [N-1:0]  last_ready;

  typedef struct {
    logic [3:0]    rv;
    logic [3:0]    ready;
    logic          fu_v;
    logic [1:0]    src;
    logic [TW-1:0] ftag;
    logic          dn_v;
    logic [TW-1:0] dtag;
    logic          bsy;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d, t=%0t)", name, act, exp, cyc, $time);
    end
  endtask

  task automatic model_reset();
    m_lfsr   = 8'hA5;
    m_act    = 0;
    m_end    = 0;
    m_tag    = '0;
    m_fu_v   = 0;
    m_fu_tag = '0;
    m_fu_src = '0;
    m_dn_v   = 0;
    m_dn_tag = '0;
    for (int i = 0; i < N; i++) m_age[i] = 0;
    cyc = 0;
  endtask

  // Called at a negedge: drive, compare against the model, advance model across the posedge.
  task automatic step(input logic [3:0] rv, input logic fl);
    logic [3:0] er;
    logic [1:0] s;
    int         w;
    bit         wok, win, g, nd;
    req_valid = rv;
    flush     = fl;
    #1;
    s   = m_lfsr[1:0];
    win = !fl && (!m_act || cyc >= m_end);
    wok = 0;
    w   = 0;
    for (int k = 0; k < N; k++) begin
      int i;
      i = (int'(s) + k) % N;
      if (!wok && rv[i]) begin
        wok = 1;
        w   = i;
      end
    end
`ifdef FU_SHARE_ARB_STARVE_GUARD_EN
    for (int i = N - 1; i >= 0; i--) begin
      if (rv[i] && m_age[i] >= STARVE_LIM) w = i;
    end
`endif
    er = (win && wok) ? 4'(1 << w) : 4'b0;
    last_ready = req_ready;
    chk("req_ready", 32'(req_ready), 32'(er));
    chk("busy", 32'(busy), 32'(m_act));
    chk("fu_valid", 32'(fu_valid), 32'(m_fu_v));
    if (m_fu_v) begin
      chk("fu_tag", 32'(fu_tag), 32'(m_fu_tag));
      chk("fu_src", 32'(fu_src), 32'(m_fu_src));
    end
    chk("done_valid", 32'(done_valid), 32'(m_dn_v));
    if (m_dn_v) chk("done_tag", 32'(done_tag), 32'(m_dn_tag));

    g  = (er != 4'b0);
    nd = !fl && m_act && (cyc == m_end);
    if (nd) m_dn_tag = m_tag;
    m_dn_v = nd;
    m_fu_v = g;
    if (g) begin
      m_fu_tag = req_tag[w*TW +: TW];
      m_fu_src = 2'(w);
    end
    if (fl) m_act = 0;
    else if (g) begin
      m_act = 1;
      m_end = cyc + LAT;
      m_tag = req_tag[w*TW +: TW];
    end else if (m_act && cyc >= m_end) m_act = 0;
    for (int i = 0; i < N; i++) begin
      if (fl || !rv[i] || (g && w == i)) m_age[i] = 0;
      else m_age[i] = m_age[i] + 1;
    end
    m_lfsr = fl ? 8'hA5 : {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    cyc++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 20) begin
      step(4'b0, 1'b0);
      n++;
    end
    chk("idle_timeout", 32'(busy), 32'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // rows are cycles after reset release; tags: req3..0 = 3C,33,22,11; lfsr A5,4A,95,2A,54,A9,53,A7,4E
    tbl[0] = '{rv:4'hF, ready:4'b0010, fu_v:0, src:0, ftag:0,     dn_v:0, dtag:0,     bsy:0};
    tbl[1] = '{rv:4'hD, ready:4'b0000, fu_v:1, src:1, ftag:6'h22, dn_v:0, dtag:0,     bsy:1};
    tbl[2] = '{rv:4'hD, ready:4'b0000, fu_v:0, src:0, ftag:0,     dn_v:0, dtag:0,     bsy:1};
    tbl[3] = '{rv:4'hD, ready:4'b0000, fu_v:0, src:0, ftag:0,     dn_v:0, dtag:0,     bsy:1};
    tbl[4] = '{rv:4'hD, ready:4'b0001, fu_v:0, src:0, ftag:0,     dn_v:0, dtag:0,     bsy:1};
    tbl[5] = '{rv:4'hC, ready:4'b0000, fu_v:1, src:0, ftag:6'h11, dn_v:1, dtag:6'h22, bsy:1};
    tbl[6] = '{rv:4'hC, ready:4'b0000, fu_v:0, src:0, ftag:0,     dn_v:0, dtag:0,     bsy:1};
    tbl[7] = '{rv:4'hC, ready:4'b0000, fu_v:0, src:0, ftag:0,     dn_v:0, dtag:0,     bsy:1};
    tbl[8] = '{rv:4'h1, ready:4'b0001, fu_v:0, src:0, ftag:0,     dn_v:0, dtag:0,     bsy:1};
    tbl[9] = '{rv:4'h0, ready:4'b0000, fu_v:1, src:0, ftag:6'h11, dn_v:1, dtag:6'h11, bsy:1};

    reset     = 1'b0;
    flush     = 1'b0;
    req_valid = 4'hF;
    req_tag   = {6'h3C, 6'h33, 6'h22, 6'h11};
    last_ready = '0;
    model_reset();
    #12;
    chk("rst_req_ready", 32'(req_ready), 32'(0));
    chk("rst_fu_valid", 32'(fu_valid), 32'(0));
    chk("rst_fu_tag", 32'(fu_tag), 32'(0));
    chk("rst_fu_src", 32'(fu_src), 32'(0));
    chk("rst_done_valid", 32'(done_valid), 32'(0));
    chk("rst_done_tag", 32'(done_tag), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    @(negedge clk);
    reset = 1'b1;

    for (int v = 0; v < 10; v++) begin
      req_valid = tbl[v].rv;
      flush     = 1'b0;
      #1;
      chk("tbl_ready", 32'(req_ready), 32'(tbl[v].ready));
      chk("tbl_busy", 32'(busy), 32'(tbl[v].bsy));
      chk("tbl_fu_valid", 32'(fu_valid), 32'(tbl[v].fu_v));
      if (tbl[v].fu_v) begin
        chk("tbl_fu_src", 32'(fu_src), 32'(tbl[v].src));
        chk("tbl_fu_tag", 32'(fu_tag), 32'(tbl[v].ftag));
      end
      chk("tbl_done_valid", 32'(done_valid), 32'(tbl[v].dn_v));
      if (tbl[v].dn_v) chk("tbl_done_tag", 32'(done_tag), 32'(tbl[v].dtag));
      step(tbl[v].rv, 1'b0);
    end

    // flush landing on the cnt==0 cycle
    wait_idle();
    step(4'hF, 1'b0);
    for (int k = 0; k < LAT - 1; k++) step(4'b0, 1'b0);
    req_valid = 4'hF;
    flush     = 1'b1;
    #1;
    chk("flush_no_grant", 32'(req_ready), 32'(0));
    chk("flush_cnt0_busy", 32'(busy), 32'(1));
    step(4'hF, 1'b1);
    #1;
    chk("flush_no_done", 32'(done_valid), 32'(0));
    chk("flush_busy_clr", 32'(busy), 32'(0));
    chk("flush_no_launch", 32'(fu_valid), 32'(0));
    chk("flush_lfsr_seed", 32'(dut.u_lfsr.q), 32'(8'hA5));

    // async reset in the launch cycle of a busy op
    wait_idle();
    req_tag = {6'h05, 6'h0A, 6'h14, 6'h28};
    step(4'hF, 1'b0);
    req_valid = 4'hF;
    #2;
    reset = 1'b0;
    #1;
    chk("arst_req_ready", 32'(req_ready), 32'(0));
    chk("arst_busy", 32'(busy), 32'(0));
    chk("arst_fu_valid", 32'(fu_valid), 32'(0));
    chk("arst_fu_tag", 32'(fu_tag), 32'(0));
    chk("arst_fu_src", 32'(fu_src), 32'(0));
    chk("arst_done_valid", 32'(done_valid), 32'(0));
    chk("arst_done_tag", 32'(done_tag), 32'(0));
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    for (int k = 0; k < LAT + 3; k++) begin
      step(4'b0, 1'b0);
      chk("arst_no_done", 32'(done_valid), 32'(0));
    end

    for (int k = 0; k < 400; k++) begin
      req_tag = 24'($urandom);
      step(4'($urandom_range(0, 15)), ($urandom_range(0, 19) == 0));
    end

`ifdef FU_SHARE_ARB_STARVE_GUARD_EN
    begin
      int a3, hits;
      bit pend;
      logic [3:0] rv;
      a3   = 0;
      hits = 0;
      pend = 0;
      for (int k = 0; k < 2000 && hits < 4; k++) begin
        rv = (k == 0) ? 4'b0 : {1'b1, ((k % 8) != 0) ? 3'b111 : 3'b000};
        step(rv, 1'b0);
        if (pend && last_ready != '0) begin
          chk("starve_grant", 32'(last_ready), 32'(4'b1000));
          pend = 0;
          hits++;
        end
        if (rv[3] && !last_ready[3]) a3++;
        else a3 = 0;
        if (a3 >= STARVE_LIM) pend = 1;
      end
      chk("starve_exercised", 32'(hits > 0), 32'(1));
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
